// File: rtl/csi_frame_sequencer_if.sv
// Header/payload strobe bundle between the header decoder, the frame
// sequencer and the payload capture datapath (rxbyteclkhs domain).
//
// Handshake semantics: there is no ready/backpressure on any signal here.
// ph_valid, pld_done, pld_start and pld_abort are single-cycle strobes that
// are consumed on the rising edge where they are high. ph_stream and
// ecc_error are only meaningful while ph_valid is high. pld_wc is a level
// that holds its value from one pld_start until the next.
interface csi_frame_sequencer_if;
  logic        ph_valid;
  logic [23:0] ph_stream;
  logic        ecc_error;
  logic        pld_done;
  logic        pld_start;
  logic        pld_abort;
  logic [15:0] pld_wc;

  // Decoder/datapath side: drives headers and payload completion.
  modport master (
    output ph_valid, ph_stream, ecc_error, pld_done,
    input  pld_start, pld_abort, pld_wc
  );

  // Sequencer side.
  modport slave (
    input  ph_valid, ph_stream, ecc_error, pld_done,
    output pld_start, pld_abort, pld_wc
  );
endinterface

// File: rtl/csi_frame_sequencer.sv
// CSI-2 receive frame sequencer: tracks FS/FE/pixel headers for one virtual
// channel and data type, starts/aborts payload capture, counts lines and
// frames and latches sticky protocol errors.
// Optional LINE watchdog: define PCKT_SEQ_TIMEOUT_EN.
// dbg_state exposes the FSM state (0 IDLE, 1 FRAME, 2 LINE).
module csi_frame_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                   rxbyteclkhs,
  input  logic                   reset,
  csi_frame_sequencer_if.slave   bus,
  input  logic [1:0]             cfg_vc,
  input  logic [5:0]             cfg_dt,
  input  logic [15:0]            cfg_lines,
  input  logic [15:0]            cfg_wc,
  input  logic                   err_clr,
  output logic                   frame_active,
  output logic                   frame_done,
  output logic [CNT_WIDTH-1:0]   line_count,
  output logic [CNT_WIDTH-1:0]   frame_count,
  output logic [5:0]             err_status,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    LINE  = 2'd2
  } state_t;

  state_t state, state_n, eff_state;

  logic                 frame_active_n, frame_done_n, start_n, abort_n;
  logic [15:0]          wc_n;
  logic [CNT_WIDTH-1:0] line_count_n, frame_count_n;
  logic [5:0]           err_set;
  logic                 timeout_hit;

  // Header decode: an accepted header is clean and on our virtual channel.
  logic        hdr;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        is_fs, is_fe, is_px;

  assign hdr_dt = bus.ph_stream[5:0];
  assign hdr_wc = bus.ph_stream[23:8];
  assign hdr    = bus.ph_valid & ~bus.ecc_error & (bus.ph_stream[7:6] == cfg_vc);
  assign is_fs  = hdr & (hdr_dt == 6'h00);
  assign is_fe  = hdr & (hdr_dt == 6'h01);
  assign is_px  = hdr & (hdr_dt == cfg_dt) & ~is_fs & ~is_fe;

  assign dbg_state = state;

`ifdef PCKT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] timer;

  // Watchdog: restart on every LINE entry, count every cycle spent in LINE.
  always_ff @(posedge rxbyteclkhs) begin
    if (reset)                timer <= '0;
    else if (start_n)         timer <= '0;
    else if (state == LINE)   timer <= timer + 1'b1;
  end

  // The limit cycle is the TIMEOUT_CYCLES-th cycle in LINE.
  assign timeout_hit = (state == LINE) && !bus.pld_done &&
                       (timer == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-output logic. A LINE cycle is first resolved
  // (completion, abort or timeout), then any header is handled as in FRAME.
  always_comb begin
    state_n        = state;
    eff_state      = state;
    frame_active_n = frame_active;
    frame_done_n   = 1'b0;
    start_n        = 1'b0;
    abort_n        = 1'b0;
    wc_n           = bus.pld_wc;
    line_count_n   = line_count;
    frame_count_n  = frame_count;
    err_set        = 6'b0;

    if (state == LINE) begin
      if (bus.pld_done) begin
        if (line_count != {CNT_WIDTH{1'b1}}) line_count_n = line_count + 1'b1;
        eff_state = FRAME;
        state_n   = FRAME;
      end else if (hdr || timeout_hit) begin
        abort_n    = 1'b1;
        err_set[4] = hdr;
        err_set[5] = timeout_hit;
        eff_state  = FRAME;
        state_n    = FRAME;
      end
    end

    if (eff_state == IDLE) begin
      if (is_fs) begin
        frame_active_n = 1'b1;
        line_count_n   = '0;
        state_n        = FRAME;
      end else if (is_fe || is_px) begin
        err_set[1] = 1'b1;
      end
    end else if (eff_state == FRAME) begin
      if (is_fs) begin
        err_set[0]   = 1'b1;
        line_count_n = '0;
      end else if (is_fe) begin
        if (cfg_lines != 16'd0 && 32'(line_count_n) != 32'(cfg_lines))
          err_set[3] = 1'b1;
        frame_count_n  = frame_count + 1'b1;
        frame_done_n   = 1'b1;
        frame_active_n = 1'b0;
        state_n        = IDLE;
      end else if (is_px) begin
        if (cfg_wc != 16'd0 && hdr_wc != cfg_wc) err_set[2] = 1'b1;
        if (hdr_wc != 16'd0) begin
          wc_n    = hdr_wc;
          start_n = 1'b1;
          state_n = LINE;
        end
      end
    end
  end

  // State and registered outputs; a newly set error wins over err_clr.
  always_ff @(posedge rxbyteclkhs) begin
    if (reset) begin
      state         <= IDLE;
      frame_active  <= 1'b0;
      frame_done    <= 1'b0;
      bus.pld_start <= 1'b0;
      bus.pld_abort <= 1'b0;
      bus.pld_wc    <= 16'd0;
      line_count    <= '0;
      frame_count   <= '0;
      err_status    <= 6'b0;
    end else begin
      state         <= state_n;
      frame_active  <= frame_active_n;
      frame_done    <= frame_done_n;
      bus.pld_start <= start_n;
      bus.pld_abort <= abort_n;
      bus.pld_wc    <= wc_n;
      line_count    <= line_count_n;
      frame_count   <= frame_count_n;
      err_status    <= (err_clr ? 6'b0 : err_status) | err_set;
    end
  end

endmodule

// File: tb/tb_csi_frame_sequencer.sv
// Directed bench for csi_frame_sequencer; builds with or without
// PCKT_SEQ_TIMEOUT_EN (watchdog limit shortened to 16 when defined).
module tb_csi_frame_sequencer;

`ifdef PCKT_SEQ_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  // Clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  csi_frame_sequencer_if bus();

  logic [1:0]  cfg_vc;
  logic [5:0]  cfg_dt;
  logic [15:0] cfg_lines, cfg_wc;
  logic        err_clr;
  logic        frame_active, frame_done;
  logic [15:0] line_count, frame_count;
  logic [5:0]  err_status;
  logic [1:0]  dbg_state;

  csi_frame_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut (
    .rxbyteclkhs (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .cfg_vc      (cfg_vc),
    .cfg_dt      (cfg_dt),
    .cfg_lines   (cfg_lines),
    .cfg_wc      (cfg_wc),
    .err_clr     (err_clr),
    .frame_active(frame_active),
    .frame_done  (frame_done),
    .line_count  (line_count),
    .frame_count (frame_count),
    .err_status  (err_status),
    .dbg_state   (dbg_state)
  );

  int pass_cnt = 0;
  int total    = 0;

  // Driver tasks: inputs change #1 after a rising edge; outputs are read
  // #1 after the following edge, i.e. one cycle after the stimulus.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic [1:0] vc, input logic [5:0] dt,
                     input logic [15:0] wc, input logic ecc);
    bus.ph_valid  = 1'b1;
    bus.ph_stream = {wc, vc, dt};
    bus.ecc_error = ecc;
    step();
    bus.ph_valid  = 1'b0;
    bus.ecc_error = 1'b0;
  endtask

  task automatic done_pulse();
    bus.pld_done = 1'b1;
    step();
    bus.pld_done = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  initial begin
    logic seen;
    reset = 1'b1;
    bus.ph_valid = 1'b0; bus.ph_stream = 24'h0; bus.ecc_error = 1'b0; bus.pld_done = 1'b0;
    cfg_vc = 2'd0; cfg_dt = 6'h2B; cfg_lines = 16'd3; cfg_wc = 16'h0A00; err_clr = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    chk("rst_state", dbg_state, 0);
    chk("rst_active", frame_active, 0);
    chk("rst_start", bus.pld_start, 0);
    chk("rst_abort", bus.pld_abort, 0);
    chk("rst_wc", bus.pld_wc, 0);
    chk("rst_lines", line_count, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_err", err_status, 0);

    // Good frame of 3 lines
    hdr(2'd0, 6'h00, 16'h0, 1'b0);
    chk("fs_active", frame_active, 1);
    chk("fs_state", dbg_state, 1);
    for (int i = 0; i < 3; i++) begin
      hdr(2'd0, 6'h2B, 16'h0A00, 1'b0);
      chk("px_start", bus.pld_start, 1);
      chk("px_wc", bus.pld_wc, 32'h0A00);
      chk("px_state", dbg_state, 2);
      step();
      chk("px_start_pulse", bus.pld_start, 0);
      repeat (18) step();
      done_pulse();
      chk("line_cnt", line_count, i + 1);
      chk("line_state", dbg_state, 1);
    end
    hdr(2'd0, 6'h01, 16'h0, 1'b0);
    chk("fe_done", frame_done, 1);
    chk("fe_frames", frame_count, 1);
    chk("fe_active", frame_active, 0);
    chk("fe_lines", line_count, 3);
    chk("fe_err", err_status, 0);
    step();
    chk("fe_done_pulse", frame_done, 0);

    // FE and pixel outside a frame
    hdr(2'd0, 6'h01, 16'h0, 1'b0);
    chk("idle_fe_err", err_status, 6'b000010);
    hdr(2'd0, 6'h2B, 16'h0A00, 1'b0);
    chk("idle_px_start", bus.pld_start, 0);
    chk("idle_px_err", err_status, 6'b000010);
    chk("idle_px_active", frame_active, 0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("err_clr", err_status, 0);

    // WC mismatch, then short frame
    hdr(2'd0, 6'h00, 16'h0, 1'b0);
    hdr(2'd0, 6'h2B, 16'h0800, 1'b0);
    chk("wcm_start", bus.pld_start, 1);
    chk("wcm_wc", bus.pld_wc, 32'h0800);
    chk("wcm_err", err_status, 6'b000100);
    done_pulse();
    hdr(2'd0, 6'h2B, 16'h0A00, 1'b0);
    done_pulse();
    hdr(2'd0, 6'h01, 16'h0, 1'b0);
    chk("short_err", err_status, 6'b001100);
    chk("short_frames", frame_count, 2);
    chk("short_done", frame_done, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // FE during LINE without pld_done: abort
    cfg_lines = 16'd0;
    hdr(2'd0, 6'h00, 16'h0, 1'b0);
    hdr(2'd0, 6'h2B, 16'h0A00, 1'b0);
    hdr(2'd0, 6'h01, 16'h0, 1'b0);
    chk("trunc_abort", bus.pld_abort, 1);
    chk("trunc_err", err_status, 6'b010000);
    chk("trunc_lines", line_count, 0);
    chk("trunc_done", frame_done, 1);
    chk("trunc_frames", frame_count, 3);
    chk("trunc_state", dbg_state, 0);
    step();
    chk("trunc_abort_pulse", bus.pld_abort, 0);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // FE together with pld_done: line completes, no abort
    hdr(2'd0, 6'h00, 16'h0, 1'b0);
    hdr(2'd0, 6'h2B, 16'h0A00, 1'b0);
    bus.pld_done = 1'b1;
    hdr(2'd0, 6'h01, 16'h0, 1'b0);
    bus.pld_done = 1'b0;
    chk("same_abort", bus.pld_abort, 0);
    chk("same_lines", line_count, 1);
    chk("same_err", err_status, 0);
    chk("same_done", frame_done, 1);
    chk("same_frames", frame_count, 4);

    // Ignored headers: bad ECC, foreign VC
    hdr(2'd0, 6'h00, 16'h0, 1'b1);
    chk("ecc_state", dbg_state, 0);
    chk("ecc_active", frame_active, 0);
    hdr(2'd1, 6'h00, 16'h0, 1'b0);
    chk("vc_state", dbg_state, 0);
    chk("vc_err", err_status, 0);

    // FS inside a frame restarts it
    hdr(2'd0, 6'h00, 16'h0, 1'b0);
    chk("fs2_lines", line_count, 0);
    hdr(2'd0, 6'h2B, 16'h0A00, 1'b0);
    done_pulse();
    chk("fs2_line1", line_count, 1);
    hdr(2'd0, 6'h00, 16'h0, 1'b0);
    chk("fsin_err", err_status, 6'b000001);
    chk("fsin_lines", line_count, 0);
    chk("fsin_active", frame_active, 1);

    // err_clr with a new error in the same cycle
    hdr(2'd0, 6'h2B, 16'h0800, 1'b0);
    chk("pre_clr_err", err_status, 6'b000101);
    done_pulse();
    err_clr = 1'b1;
    hdr(2'd0, 6'h00, 16'h0, 1'b0);
    err_clr = 1'b0;
    chk("clr_race_err", err_status, 6'b000001);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // Unknown DT and zero-WC pixel inside FRAME
    hdr(2'd0, 6'h12, 16'h0A00, 1'b0);
    chk("unk_start", bus.pld_start, 0);
    chk("unk_state", dbg_state, 1);
    hdr(2'd0, 6'h2B, 16'h0000, 1'b0);
    chk("wc0_start", bus.pld_start, 0);
    chk("wc0_state", dbg_state, 1);
    chk("wc0_lines", line_count, 0);
    chk("wc0_err", err_status, 6'b000100);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // LINE watchdog
    hdr(2'd0, 6'h2B, 16'h0A00, 1'b0);
    seen = 1'b0;
`ifdef PCKT_SEQ_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.pld_abort) seen = 1'b1;
    end
    chk("to_early_abort", seen, 0);
    step();
    chk("to_abort", bus.pld_abort, 1);
    chk("to_err", err_status, 6'b100000);
    chk("to_state", dbg_state, 1);
    chk("to_lines", line_count, 0);
`else
    for (int i = 0; i < 1000; i++) begin
      step();
      if (bus.pld_abort) seen = 1'b1;
    end
    chk("noto_abort", seen, 0);
    chk("noto_state", dbg_state, 2);
    chk("noto_err", err_status, 0);
    done_pulse();
    chk("noto_lines", line_count, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/csi_frame_sequencer.md
Name: csi_frame_sequencer

Overview:
Controller that sequences the CSI-2 receive payload datapath from decoded packet headers. It tracks frame state per configured virtual channel and data type, and issues start/abort commands with the word count to the payload capture datapath. It counts lines and frames and latches sticky protocol errors. It sits between the header/ECC decoder and the payload datapath, all in the rxbyteclkhs domain.

Parameters:
TIMEOUT_CYCLES, 4096, LINE-state watchdog limit in byte clocks; used only with the optional feature.
CNT_WIDTH, 16, width of line_count and frame_count.

Ports:
rxbyteclkhs  in  1  byte clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
ph_valid  in  1  one-cycle strobe; ph_stream holds a decoded header.
ph_stream  in  24  {WC_MSB[23:16], WC_LSB[15:8], DATA_ID[7:0]}; DATA_ID[7:6]=VC, [5:0]=DT.
ecc_error  in  1  qualifies ph_valid; header discarded when 1.
pld_done  in  1  strobe from datapath: long-packet payload fully consumed.
cfg_vc  in  2  accepted virtual channel.
cfg_dt  in  6  accepted pixel data type (e.g. 0x2B RAW10).
cfg_lines  in  16  expected lines per frame; 0 disables check.
cfg_wc  in  16  expected word count per line; 0 disables check.
err_clr  in  1  clears err_status.
pld_start  out  1  one-cycle strobe: begin payload capture.
pld_abort  out  1  one-cycle strobe: abandon current payload.
pld_wc  out  16  word count for the current line, held until the next start.
frame_active  out  1  high between accepted FS and FE.
frame_done  out  1  one-cycle strobe on accepted FE.
line_count  out  CNT_WIDTH  completed lines in current frame.
frame_count  out  CNT_WIDTH  completed frames, wraps modulo 2^CNT_WIDTH.
err_status  out  6  sticky: [0] FS in frame, [1] FE/pixel packet outside frame, [2] WC mismatch, [3] line-count mismatch, [4] truncated line, [5] timeout.

Behaviour:
- Reset: every output 0, state IDLE, counters 0, pld_wc 0.
- Accepted header (hdr): ph_valid & ~ecc_error & VC==cfg_vc. All other headers are ignored with no state or error change.
- Header classes: DT 0x00 FS, 0x01 FE, DT==cfg_dt pixel. All other DTs are ignored.
- Latency: every output changes in the cycle after the triggering input.
- IDLE:
  - hdr FS: frame_active<=1, line_count<=0, next state FRAME.
  - hdr FE or pixel: set err[1], stay in IDLE, no pld_start.
- FRAME:
  - hdr FS: set err[0], line_count<=0, stay in FRAME (frame restarts).
  - hdr FE: if cfg_lines!=0 and line_count!=cfg_lines, set err[3]. Then frame_count+1, frame_done pulse, frame_active<=0, next state IDLE.
  - hdr pixel: if cfg_wc!=0 and WC!=cfg_wc, set err[2].
    - WC==0: no start, line not counted, stay in FRAME.
    - Otherwise: pld_wc<=WC, pld_start pulse, next state LINE. A mismatched WC is still captured.
- LINE:
  - pld_done: line_count+1 (saturating at all-ones), next state FRAME.
  - hdr (any class) without pld_done: set err[4], pulse pld_abort, line not counted. The header is processed in the same cycle exactly as in FRAME.
  - pld_done and hdr in the same cycle: line completes first, then the header is processed as in FRAME; no err[4].
- pld_done outside LINE is ignored.
- err_clr: clears all err bits; an error set in the same cycle wins.
- Reset mid-line: immediate return to IDLE, no pld_abort; the datapath shares the reset.

Optional Feature:
- Macro PCKT_SEQ_TIMEOUT_EN.
- Defined: a cycle counter clears on LINE entry and increments each LINE cycle. When it reaches TIMEOUT_CYCLES without pld_done: set err[5], pulse pld_abort, line not counted, next state FRAME. pld_done in the limit cycle wins.
- Undefined: no counter, err[5] tied 0, LINE waits indefinitely.

Test Plan:
- Frame, cfg_lines=3, cfg_wc=0x0A00: FS, then 3×(pixel WC=0x0A00, pld_done 20 cycles later), FE -> 3 pld_start pulses, each one cycle after ph_valid with pld_wc=0x0A00; line_count=3; frame_done pulse; frame_count=1; err_status=0.
- FE in IDLE, then pixel in IDLE -> err_status=6'b000010, no pld_start, frame_active=0.
- Pixel WC=0x0800 with cfg_wc=0x0A00 inside frame -> err[2]=1, pld_start with pld_wc=0x0800. FE after 2 lines with cfg_lines=3 -> err[3]=1, frame_count still increments.
- In LINE, FE arrives without pld_done -> pld_abort pulse, err[4]=1, line_count unchanged, frame_done next cycle. Repeat with pld_done in the same cycle -> no abort, line counted.
- ph_valid with ecc_error=1 carrying FS, and FS on VC≠cfg_vc -> no state change. FS on cfg_vc while in FRAME -> err[0], line_count=0. err_clr asserted with a new error in the same cycle -> that bit remains set.
- With PCKT_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16: pixel start, no pld_done -> at cycle 16 pld_abort pulse, err[5]=1, state FRAME. Without the macro -> no abort after 1000 cycles.
